// File: rtl/vram_scheduler.sv
// Slot scheduler for the 8-bit video SRAM: posts CPU word writes as two byte
// beats in fixed windows (P0-P2, P3-P5) and runs one video fetch in P7.
module vram_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 15
) (
    input  logic                       VCLK,
    input  logic                       Reset,
    input  logic                       LineStart,
    input  logic                       WrReq,
    input  logic [AW-1:0]              WrAddr,
    input  logic [15:0]                WrData,
    input  logic [1:0]                 WrBE,
    input  logic [AW-1:0]              FetchAddr,
    input  logic                       FetchHi,
    input  logic                       FetchEn,
    input  logic                       OvfClr,
    output logic [2:0]                 Phase,
    output logic [AW-1:0]              RA,
    output logic                       nRCS0,
    output logic                       nRCS1,
    output logic                       nRWE,
    output logic                       nROE,
    output logic [7:0]                 RDout,
    output logic                       RDOE,
    output logic                       FetchStrobe,
    output logic [$clog2(DEPTH):0]     WrCount,
    output logic                       WrOvf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5, P6, P7} phase_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [1:0]    be;
    } ent_t;

    phase_t        phase_q, phase_d;
    ent_t          mem_q [DEPTH];
    ent_t          new_ent, head, head_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, armed_q, armed_d, push, pop;
    logic [AW-1:0] ra_q, ra_d;
    logic          cs0_q, cs0_d, cs1_q, cs1_d, we_q, we_d, oe_q, oe_d;
    logic [7:0]    rdout_q, rdout_d;
    logic          rdoe_q, rdoe_d, strobe_q, strobe_d;

    always_comb begin
        new_ent  = '{addr: WrAddr, data: WrData, be: WrBE};
        head     = mem_q[rd_ptr_q];
        pop      = armed_q && (phase_q == P2 || phase_q == P5) && !LineStart;
        push     = WrReq && (count_q < CW'(DEPTH) || pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        ovf_d    = (WrReq && !push) ? 1'b1 : (OvfClr ? 1'b0 : ovf_q);
        // An empty queue after the pop means the incoming word becomes head
        head_d   = (count_q == CW'(pop)) ? new_ent : mem_q[rd_ptr_d];
        phase_d  = LineStart ? P0 : phase_t'(phase_q + 3'd1);

        armed_d  = armed_q;
        ra_d     = ra_q;
        rdout_d  = rdout_q;
        cs0_d    = 1'b1;
        cs1_d    = 1'b1;
        we_d     = 1'b1;
        oe_d     = 1'b1;
        rdoe_d   = 1'b0;
        strobe_d = 1'b0;

        unique case (phase_d)
            P0, P3: begin
                armed_d = (count_d != '0);
                rdoe_d  = (phase_d == P3);
                if (count_d != '0) ra_d = head_d.addr;
            end
            P1, P4: begin
                if (armed_q) begin
                    cs0_d   = ~head.be[0];
                    we_d    = 1'b0;
                    rdout_d = head.data[7:0];
                    rdoe_d  = 1'b1;
                end
            end
            P2, P5: begin
                if (armed_q) begin
                    cs1_d   = ~head.be[1];
                    we_d    = 1'b0;
                    rdout_d = head.data[15:8];
                    rdoe_d  = 1'b1;
                end
            end
            P6: armed_d = 1'b0;
            P7: begin
                armed_d = 1'b0;
                ra_d    = FetchAddr;
                if (FetchEn) begin
                    oe_d     = 1'b0;
                    cs0_d    = FetchHi;
                    cs1_d    = ~FetchHi;
                    strobe_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge VCLK) begin
        if (Reset) begin
            phase_q  <= P0;
            ra_q     <= '0;
            cs0_q    <= 1'b1;
            cs1_q    <= 1'b1;
            we_q     <= 1'b1;
            oe_q     <= 1'b1;
            rdout_q  <= '0;
            rdoe_q   <= 1'b0;
            strobe_q <= 1'b0;
            armed_q  <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            ra_q     <= ra_d;
            cs0_q    <= cs0_d;
            cs1_q    <= cs1_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            rdout_q  <= rdout_d;
            rdoe_q   <= rdoe_d;
            strobe_q <= strobe_d;
            armed_q  <= armed_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge VCLK) begin
        if (push) mem_q[wr_ptr_q] <= new_ent;
    end

    assign Phase       = phase_q;
    assign RA          = ra_q;
    assign nRCS0       = cs0_q;
    assign nRCS1       = cs1_q;
    assign nRWE        = we_q;
    assign nROE        = oe_q;
    assign RDout       = rdout_q;
    assign RDOE        = rdoe_q;
    assign FetchStrobe = strobe_q;
    assign WrCount     = count_q;
    assign WrOvf       = ovf_q;
endmodule

// File: tb/tb_vram_scheduler.sv
// Randomized scoreboard bench for vram_scheduler: accepted writes are queued
// and matched against the SRAM beats observed on the bus.
module tb_vram_scheduler;
    localparam int DEPTH = 4;
    localparam int AW    = 15;

    logic          clk = 1'b0;
    logic          rst, ls, wrq, fhi, fen, oclr;
    logic [AW-1:0] waddr, faddr;
    logic [15:0]   wdata;
    logic [1:0]    wbe;
    logic [2:0]    phase;
    logic [AW-1:0] ra;
    logic          cs0, cs1, we, oe, rdoe, strobe, ovf;
    logic [7:0]    rdout;
    logic [2:0]    wrcount;

    vram_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
        .VCLK(clk), .Reset(rst), .LineStart(ls), .WrReq(wrq),
        .WrAddr(waddr), .WrData(wdata), .WrBE(wbe),
        .FetchAddr(faddr), .FetchHi(fhi), .FetchEn(fen), .OvfClr(oclr),
        .Phase(phase), .RA(ra), .nRCS0(cs0), .nRCS1(cs1), .nRWE(we),
        .nROE(oe), .RDout(rdout), .RDOE(rdoe), .FetchStrobe(strobe),
        .WrCount(wrcount), .WrOvf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [1:0]    be;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  run   = 0;

    // Reference state: phase of the current cycle and the queue occupancy
    int            m_phase, m_cnt;
    bit            m_armed, m_ovf, m_rstd;
    bit            m_fen, m_fhi;
    logic [AW-1:0] m_faddr;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop, push;
        int np;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_armed = 0; m_ovf = 0; m_rstd = 1;
            exp_q.delete();
            return;
        end
        m_rstd = 0;
        pop  = m_armed && (m_phase == 2 || m_phase == 5) && !ls;
        push = wrq && (m_cnt < DEPTH || pop);
        if (wrq && !push) m_ovf = 1;
        else if (oclr) m_ovf = 0;
        if (push) exp_q.push_back('{a: waddr, d: wdata, be: wbe});
        m_cnt = m_cnt + int'(push) - int'(pop);
        np = ls ? 0 : (m_phase + 1) % 8;
        if (np == 0 || np == 3) m_armed = (m_cnt > 0);
        else if (np >= 6) m_armed = 0;
        if (np == 7) begin
            m_fen = fen; m_fhi = fhi; m_faddr = faddr;
        end
        m_phase = np;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Monitor: compares bus activity against the scoreboard every cycle
    initial begin
        bit prev_hi = 0;
        logic [5:0] ctl;
        wr_t h;
        forever begin
            @(negedge clk);
            if (run) begin
                chk("phase", 32'(phase), 32'(m_phase));
                chk("wrcount", 32'(wrcount), 32'(m_cnt));
                chk("wrovf", 32'(ovf), 32'(m_ovf));
                if (m_rstd) begin
                    chk("reset_ra", 32'(ra), 32'd0);
                    chk("reset_rdout", 32'(rdout), 32'd0);
                end
                if ((m_phase == 3 || m_phase == 6) && prev_hi) begin
                    if (exp_q.size() == 0) chk("pop_empty", 32'd1, 32'd0);
                    else void'(exp_q.pop_front());
                end
                h = '{a: '0, d: '0, be: '0};
                if (m_armed) begin
                    if (exp_q.size() == 0) chk("armed_empty", 32'd1, 32'd0);
                    else h = exp_q[0];
                end
                ctl = 6'b111100;
                case (m_phase)
                    0, 3: begin
                        ctl = {5'b11110, 1'b0} | {4'b0, 1'(m_phase == 3), 1'b0};
                        if (m_armed) chk("setup_ra", 32'(ra), 32'(h.a));
                    end
                    1, 4: if (m_armed) begin
                        ctl = {~h.be[0], 5'b10110};
                        chk("lo_ra", 32'(ra), 32'(h.a));
                        chk("lo_data", 32'(rdout), 32'(h.d[7:0]));
                    end
                    2, 5: if (m_armed) begin
                        ctl = {1'b1, ~h.be[1], 4'b0110};
                        chk("hi_ra", 32'(ra), 32'(h.a));
                        chk("hi_data", 32'(rdout), 32'(h.d[15:8]));
                    end
                    7: if (m_fen) begin
                        ctl = {m_fhi, ~m_fhi, 4'b1001};
                        chk("fetch_ra", 32'(ra), 32'(m_faddr));
                    end
                    default: ;
                endcase
                chk($sformatf("ctl_p%0d", m_phase),
                    32'({cs0, cs1, we, oe, rdoe, strobe}), 32'(ctl));
                prev_hi = (m_phase == 2 || m_phase == 5) && m_armed;
            end
        end
    end

    task automatic rand_cycles(int n, int wprob);
        for (int i = 0; i < n; i++) begin
            rst   = ($urandom_range(0, 599) == 0);
            ls    = ($urandom_range(0, 99) < 3);
            wrq   = ($urandom_range(0, 99) < wprob);
            waddr = AW'($urandom);
            wdata = 16'($urandom);
            wbe   = 2'($urandom);
            fen   = 1'($urandom);
            fhi   = 1'($urandom);
            faddr = AW'($urandom);
            oclr  = ($urandom_range(0, 99) < 5);
            step();
        end
    endtask

    initial begin
        rst = 1; ls = 0; wrq = 0; waddr = '0; wdata = '0; wbe = '0;
        fen = 0; fhi = 0; faddr = '0; oclr = 0;
        m_phase = 0; m_cnt = 0; m_armed = 0; m_ovf = 0; m_rstd = 0;
        m_fen = 0; m_fhi = 0; m_faddr = '0;
        run = 1;
        repeat (3) step();
        rst = 0;
        for (int i = 0; i < 8 && m_phase != 2; i++) step();
        wrq = 1; waddr = 15'h1234; wdata = 16'hA55A; wbe = 2'b11;
        step();
        wrq = 0;
        fen = 1; fhi = 1; faddr = 15'h0100;
        repeat (10) step();
        rand_cycles(1000, 10);
        rand_cycles(1000, 40);
        rand_cycles(1000, 85);
        rst = 0; ls = 0; wrq = 0; oclr = 1;
        repeat (40) step();
        run = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
